// File: rtl/ctrl_encode_def.sv
// Shared encodings for the MEM-stage data-memory path: DMType codes, access FSM states
// and the request legality check.
package ctrl_encode_def;

    localparam logic [2:0] dm_word              = 3'b000;
    localparam logic [2:0] dm_halfword          = 3'b001;
    localparam logic [2:0] dm_halfword_unsigned = 3'b010;
    localparam logic [2:0] dm_byte              = 3'b011;
    localparam logic [2:0] dm_byte_unsigned     = 3'b100;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_BUSY = 2'd1,
        DMA_RESP = 2'd2
    } dma_state_e;

    // A request is illegal on an unknown width, a read+write mix, or a misaligned half/word.
    function automatic logic dm_illegal(input logic rd, input logic wr,
                                        input logic [2:0] dmtype, input logic [1:0] offset);
        logic bad;
        bad = rd & wr;
        case (dmtype)
            dm_word:                           bad = bad | (offset != 2'b00);
            dm_halfword, dm_halfword_unsigned: bad = bad | offset[0];
            dm_byte, dm_byte_unsigned:         bad = bad;
            default:                           bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering between the 32-bit RAM word and right-aligned core data:
// store byte enables / shifted data, and load lane select with sign/zero extension.
module dm_lane_align
    import ctrl_encode_def::*;
(
    input  logic [2:0]  dmtype,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic is_byte;
    logic is_half;

    assign is_byte = (dmtype == dm_byte) || (dmtype == dm_byte_unsigned);
    assign is_half = (dmtype == dm_halfword) || (dmtype == dm_halfword_unsigned);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        always_comb begin
            if (is_byte) begin
                be[gi]              = (offset == LANE);
                wdata_lane[8*gi +: 8] = wdata[7:0];
            end else if (is_half) begin
                be[gi]              = (offset[1] == LANE[1]);
                wdata_lane[8*gi +: 8] = LANE[0] ? wdata[15:8] : wdata[7:0];
            end else begin
                be[gi]              = 1'b1;
                wdata_lane[8*gi +: 8] = wdata[8*gi +: 8];
            end
        end
    end

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] shifted;

    assign shifted  = rword >> {offset, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = offset[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        load_data = rword;
        case (dmtype)
            dm_halfword:          load_data = {{16{half_sel[15]}}, half_sel};
            dm_halfword_unsigned: load_data = {16'h0000, half_sel};
            dm_byte:              load_data = {{24{byte_sel[7]}}, byte_sel};
            dm_byte_unsigned:     load_data = {24'h000000, byte_sel};
            default:              load_data = rword;
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// MEM-stage data-memory responder: word-organised RAM behind a fixed-latency
// IDLE/BUSY/RESP handshake that stalls the pipeline until done.
module dm_access_unit
    import ctrl_encode_def::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  DMType,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        stall
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    dma_state_e       state_reg, state_next;
    logic [3:0]       lat_cnt_reg, lat_cnt_next;
    logic [IDX_W+1:0] addr_reg;
    logic [31:0]      wdata_reg;
    logic [2:0]       dmtype_reg;
    logic             rd_reg, wr_reg, err_reg;
    logic [31:0]      rd_word_reg;
    logic [31:0]      rdata_hold_reg;

    logic             accept, illegal, enter_resp;
    logic [IDX_W+1:0] acc_addr;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      acc_wdata;
    logic [2:0]       acc_dmtype;
    logic             acc_rd, acc_wr, acc_err;
    logic             store_en, load_en, load_resp;
    logic [3:0]       be;
    logic [31:0]      wdata_lane, load_data;
    logic             unused_addr;

    assign unused_addr = ^addr[31:IDX_W+2];

    assign accept  = (state_reg == DMA_IDLE) && req_valid && (MemRead || MemWrite);
    assign illegal = dm_illegal(MemRead, MemWrite, DMType, addr[1:0]);

    // In IDLE the access is still on the input bus; afterwards the captured copy is used.
    always_comb begin
        if (state_reg == DMA_IDLE) begin
            acc_addr   = addr[IDX_W+1:0];
            acc_wdata  = wdata;
            acc_dmtype = DMType;
            acc_rd     = MemRead;
            acc_wr     = MemWrite;
            acc_err    = illegal;
        end else begin
            acc_addr   = addr_reg;
            acc_wdata  = wdata_reg;
            acc_dmtype = dmtype_reg;
            acc_rd     = rd_reg;
            acc_wr     = wr_reg;
            acc_err    = err_reg;
        end
    end

    assign acc_idx = acc_addr[IDX_W+1:2];

    always_comb begin
        state_next   = state_reg;
        lat_cnt_next = lat_cnt_reg;
        enter_resp   = 1'b0;
        case (state_reg)
            DMA_IDLE: begin
                if (accept) begin
                    if (illegal || LATENCY == 1) begin
                        state_next   = DMA_RESP;
                        enter_resp   = 1'b1;
                        lat_cnt_next = 4'd0;
                    end else begin
                        state_next   = DMA_BUSY;
                        lat_cnt_next = 4'(LATENCY - 1);
                    end
                end
            end
            DMA_BUSY: begin
                lat_cnt_next = lat_cnt_reg - 4'd1;
                if (lat_cnt_reg == 4'd1) begin
                    state_next = DMA_RESP;
                    enter_resp = 1'b1;
                end
            end
            DMA_RESP: state_next = DMA_IDLE;
            default:  state_next = DMA_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= DMA_IDLE;
            lat_cnt_reg <= 4'd0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            dmtype_reg  <= '0;
            rd_reg      <= 1'b0;
            wr_reg      <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lat_cnt_reg <= lat_cnt_next;
            if (accept) begin
                addr_reg   <= addr[IDX_W+1:0];
                wdata_reg  <= wdata;
                dmtype_reg <= DMType;
                rd_reg     <= MemRead;
                wr_reg     <= MemWrite;
                err_reg    <= illegal;
            end
        end
    end

    dm_lane_align u_lane_align (
        .dmtype     (acc_dmtype),
        .offset     (acc_addr[1:0]),
        .wdata      (acc_wdata),
        .rword      (rd_word_reg),
        .be         (be),
        .wdata_lane (wdata_lane),
        .load_data  (load_data)
    );

    // rstn gate keeps a request parked on the bus during reset from touching the RAM.
    assign store_en = enter_resp && acc_wr && !acc_err && rstn;
    assign load_en  = enter_resp && acc_rd && !acc_err;

    always_ff @(posedge clk) begin
        if (load_en) begin
            rd_word_reg <= mem[acc_idx];
        end
        if (store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[acc_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
                end
            end
        end
    end

    assign load_resp = (state_reg == DMA_RESP) && rd_reg && !err_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_hold_reg <= '0;
        end else if (load_resp) begin
            rdata_hold_reg <= load_data;
        end
    end

    assign rdata = load_resp ? load_data : rdata_hold_reg;
    assign done  = (state_reg == DMA_RESP);
    assign err   = done && err_reg;
    assign stall = req_valid && !done;

endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboarded bench for dm_access_unit: a LATENCY=2 and a LATENCY=1 instance sharing
// the request bus, each with its own req_valid.
module tb_dm_access_unit;
    import ctrl_encode_def::*;

    logic        clk;
    logic        rstn;
    logic        req_valid0, req_valid1;
    logic        mem_read, mem_write;
    logic [2:0]  dmtype;
    logic [31:0] addr, wdata;
    logic [31:0] rdata0, rdata1;
    logic        done0, done1, err0, err1, stall0, stall1;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] last_load [2];

    dm_access_unit #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid0), .MemRead(mem_read),
        .MemWrite(mem_write), .DMType(dmtype), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .done(done0), .err(err0), .stall(stall0)
    );

    dm_access_unit #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid1), .MemRead(mem_read),
        .MemWrite(mem_write), .DMType(dmtype), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .done(done1), .err(err1), .stall(stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access on instance sel; called and returning on a negedge with the DUT in IDLE.
    task automatic do_access(input int sel, input string tag, input logic rd, input logic wr,
                             input logic [2:0] dt, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input logic exp_e, input bit drop_mid);
        exp_t e, got_e;
        int   cyc;
        bit   seen;
        logic cur_done, cur_stall, cur_err;
        logic [31:0] cur_rdata;
        if (rd && !exp_e) last_load[sel] = exp_rd;
        e.rdata = last_load[sel];
        e.err   = exp_e;
        e.lat   = exp_e ? 1 : (sel == 1 ? 1 : 2);
        sb_q.push_back(e);

        mem_read = rd; mem_write = wr; dmtype = dt; addr = a; wdata = wd;
        if (sel == 1) req_valid1 = 1'b1; else req_valid0 = 1'b1;
        cyc  = 0;
        seen = 0;
        cur_rdata = '0;
        cur_err   = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            cur_done  = (sel == 1) ? done1 : done0;
            cur_stall = (sel == 1) ? stall1 : stall0;
            if (cur_done) begin
                seen      = 1;
                cur_rdata = (sel == 1) ? rdata1 : rdata0;
                cur_err   = (sel == 1) ? err1 : err0;
            end else if (drop_mid) begin
                if (sel == 1) req_valid1 = 1'b0; else req_valid0 = 1'b0;
            end else begin
                check_val({tag, " stall"}, 32'(cur_stall), 32'd1);
            end
        end
        got_e = sb_q.pop_front();
        check_val({tag, " done seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check_val({tag, " rdata"}, cur_rdata, got_e.rdata);
            check_val({tag, " err"}, 32'(cur_err), 32'(got_e.err));
            check_val({tag, " latency"}, 32'(cyc), 32'(got_e.lat));
        end
        $display("[TB] dut%0d %s addr=%h wdata=%h rdata=%h err=%b latency=%0d",
                 sel, tag, a, wd, cur_rdata, cur_err, cyc);
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cur_done = (sel == 1) ? done1 : done0;
        check_val({tag, " done one-cycle"}, 32'(cur_done), 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0;
        dmtype = dm_word; addr = '0; wdata = '0;
        last_load[0] = '0; last_load[1] = '0;
        repeat (2) @(negedge clk);
        check_val("reset done", 32'(done0), 32'd0);
        check_val("reset err", 32'(err0), 32'd0);
        check_val("reset rdata", rdata0, 32'd0);
        check_val("reset stall", 32'(stall0), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        do_access(0, "sw",  0, 1, dm_word, 32'h10, 32'hDEADBEEF, '0, 0, 0);
        do_access(0, "lw",  1, 0, dm_word, 32'h10, '0, 32'hDEADBEEF, 0, 0);
        do_access(0, "sw",  0, 1, dm_word, 32'h10, 32'h11223344, '0, 0, 0);
        do_access(0, "sb",  0, 1, dm_byte, 32'h13, 32'h000000A5, '0, 0, 0);
        do_access(0, "lb",  1, 0, dm_byte, 32'h13, '0, 32'hFFFFFFA5, 0, 0);
        do_access(0, "lbu", 1, 0, dm_byte_unsigned, 32'h13, '0, 32'h000000A5, 0, 0);
        do_access(0, "lw",  1, 0, dm_word, 32'h10, '0, 32'hA5223344, 0, 0);
        do_access(0, "lb+", 1, 0, dm_byte, 32'h11, '0, 32'h00000033, 0, 0);
        do_access(0, "sh",  0, 1, dm_halfword, 32'h12, 32'h00008001, '0, 0, 0);
        do_access(0, "lh",  1, 0, dm_halfword, 32'h12, '0, 32'hFFFF8001, 0, 0);
        do_access(0, "lhu", 1, 0, dm_halfword_unsigned, 32'h12, '0, 32'h00008001, 0, 0);
        do_access(0, "lh mis", 1, 0, dm_halfword, 32'h11, '0, '0, 1, 0);
        do_access(0, "lw",  1, 0, dm_word, 32'h10, '0, 32'h80013344, 0, 0);
        do_access(0, "sw",  0, 1, dm_word, 32'h20, 32'hCAFEF00D, '0, 0, 0);
        do_access(0, "sw mis", 0, 1, dm_word, 32'h22, 32'h99999999, '0, 1, 0);
        do_access(0, "lw",  1, 0, dm_word, 32'h20, '0, 32'hCAFEF00D, 0, 0);
        do_access(0, "bad type", 1, 0, 3'b110, 32'h20, '0, '0, 1, 0);
        do_access(0, "rd+wr", 1, 1, dm_word, 32'h20, 32'h0, '0, 1, 0);
        do_access(0, "sw drop", 0, 1, dm_word, 32'h50, 32'h600DF00D, '0, 0, 1);
        do_access(0, "lw",  1, 0, dm_word, 32'h50, '0, 32'h600DF00D, 0, 0);

        // A request with neither read nor write is never completed.
        req_valid0 = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("noop done", 32'(done0), 32'd0);
            check_val("noop stall", 32'(stall0), 32'd1);
        end
        req_valid0 = 1'b0;
        @(negedge clk);

        do_access(0, "sw",  0, 1, dm_word, 32'h30, 32'h0BADC0DE, '0, 0, 0);
        do_access(0, "lw",  1, 0, dm_word, 32'h30, '0, 32'h0BADC0DE, 0, 0);

        // Reset lands while the store is still in BUSY.
        mem_write = 1'b1; dmtype = dm_word; addr = 32'h30; wdata = 32'h12345678;
        req_valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("busy done", 32'(done0), 32'd0);
        check_val("busy stall", 32'(stall0), 32'd1);
        rstn = 1'b0;
        #1;
        req_valid0 = 1'b0; mem_write = 1'b0;
        check_val("rst done", 32'(done0), 32'd0);
        check_val("rst err", 32'(err0), 32'd0);
        check_val("rst rdata", rdata0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst no done", 32'(done0), 32'd0);
        end
        last_load[0] = '0;
        last_load[1] = '0;
        rstn = 1'b1;
        @(negedge clk);
        check_val("post-rst done", 32'(done0), 32'd0);
        do_access(0, "lw old", 1, 0, dm_word, 32'h30, '0, 32'h0BADC0DE, 0, 0);

        do_access(1, "sw",  0, 1, dm_word, 32'h40, 32'h55AA55AA, '0, 0, 0);
        do_access(1, "lw",  1, 0, dm_word, 32'h40, '0, 32'h55AA55AA, 0, 0);
        do_access(1, "sw alias", 0, 1, dm_word, 32'h1000, 32'h13572468, '0, 0, 0);
        do_access(1, "lw w0", 1, 0, dm_word, 32'h0, '0, 32'h13572468, 0, 0);
        do_access(1, "lb alias", 1, 0, dm_byte, 32'h1003, '0, 32'h00000013, 0, 0);
        do_access(1, "sw mis", 0, 1, dm_word, 32'h41, 32'h0, '0, 1, 0);
        do_access(1, "lhu", 1, 0, dm_halfword_unsigned, 32'h42, '0, 32'h000055AA, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
